// File: rtl/noc_ingress_framer_if.sv
// Byte-stream ingress and FIFO-0 write port of the NoC ingress framer.
// master: framer side; slave: byte source plus downstream FIFO side.
interface noc_ingress_framer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       fifo_full;
    logic       fifo_wr_en;
    logic [7:0] fifo_data;

    modport master (
        input  in_data, in_valid, fifo_full,
        output in_ready, fifo_wr_en, fifo_data
    );

    modport slave (
        output in_data, in_valid, fifo_full,
        input  in_ready, fifo_wr_en, fifo_data
    );
endinterface

// File: rtl/noc_ingress_framer.sv
// Frames the raw input byte stream into length-checked NoC packets for FIFO 0,
// dropping malformed headers and zero-padding stalled packets. Define FRAMER_CSUM_EN to append an XOR checksum byte.
module noc_ingress_framer #(
    parameter int unsigned NUM_TILES = 4,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    noc_ingress_framer_if.master        bus,
    output logic                        busy,
    output logic                        err_drop,
    output logic                        err_timeout,
    output logic [7:0]                  pkt_count
);

    localparam int unsigned REM_W  = 5;
    localparam int unsigned IDLE_W = 8;

    typedef struct packed {
        logic [1:0] dest;
        logic [1:0] opcode;
        logic [3:0] len_m1;
    } hdr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_PAD,
`ifdef FRAMER_CSUM_EN
        S_CSUM,
`endif
        S_DROP
    } state_t;

`ifdef FRAMER_CSUM_EN
    localparam state_t S_DONE = S_CSUM;
`else
    localparam state_t S_DONE = S_IDLE;
`endif

    state_t              state_q, state_n;
    logic [7:0]          oreg_q;
    logic                oval_q;
    logic [REM_W-1:0]    rem_q, rem_n;
    logic [IDLE_W-1:0]   idle_q, idle_n;
    logic                ready_c, load_c, pkt_inc_c, drop_c, tmo_c, can_load_c, last_c, hdr_ok_c;
    logic [7:0]          load_byte_c;
    hdr_t                hdr_c;
`ifdef FRAMER_CSUM_EN
    logic [7:0]          csum_q, csum_n;
`endif

    assign hdr_c      = hdr_t'(bus.in_data);
    assign hdr_ok_c   = (32'(hdr_c.dest) < NUM_TILES) && (hdr_c.opcode != 2'b11);
    assign can_load_c = !oval_q || !bus.fifo_full;
    assign last_c     = (rem_q == REM_W'(1));

    assign bus.in_ready   = rst_n & ready_c;
    assign bus.fifo_wr_en = oval_q & ~bus.fifo_full;
    assign bus.fifo_data  = oreg_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    // Next-state, handshake and output-register load decisions
    always_comb begin
        state_n     = state_q;
        rem_n       = rem_q;
        idle_n      = idle_q;
        ready_c     = 1'b0;
        load_c      = 1'b0;
        load_byte_c = bus.in_data;
        pkt_inc_c   = 1'b0;
        drop_c      = 1'b0;
        tmo_c       = 1'b0;
`ifdef FRAMER_CSUM_EN
        csum_n      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                ready_c = can_load_c;
                if (bus.in_valid && ready_c) begin
                    rem_n = REM_W'({1'b0, hdr_c.len_m1}) + REM_W'(1);
                    if (hdr_ok_c) begin
                        load_c  = 1'b1;
                        idle_n  = '0;
                        state_n = S_PAYLOAD;
`ifdef FRAMER_CSUM_EN
                        csum_n  = bus.in_data;
`endif
                    end else begin
                        state_n = S_DROP;
                    end
                end
            end
            S_PAYLOAD: begin
                ready_c = can_load_c;
                if (bus.in_valid && ready_c) begin
                    load_c = 1'b1;
                    rem_n  = rem_q - REM_W'(1);
                    idle_n = '0;
`ifdef FRAMER_CSUM_EN
                    csum_n = csum_q ^ bus.in_data;
`endif
                    if (last_c) begin
                        pkt_inc_c = 1'b1;
                        state_n   = S_DONE;
                    end
                end else if (!bus.in_valid) begin
                    // Only source silence counts; backpressure never aborts a packet.
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        tmo_c   = 1'b1;
                        idle_n  = '0;
                        state_n = S_PAD;
                    end else begin
                        idle_n = idle_q + IDLE_W'(1);
                    end
                end
            end
            S_PAD: begin
                if (can_load_c) begin
                    load_c      = 1'b1;
                    load_byte_c = 8'h00;
                    rem_n       = rem_q - REM_W'(1);
                    if (last_c) begin
                        pkt_inc_c = 1'b1;
                        state_n   = S_DONE;
                    end
                end
            end
`ifdef FRAMER_CSUM_EN
            S_CSUM: begin
                if (can_load_c) begin
                    load_c      = 1'b1;
                    load_byte_c = csum_q;
                    state_n     = S_IDLE;
                end
            end
`endif
            S_DROP: begin
                ready_c = 1'b1;
                if (bus.in_valid) begin
                    rem_n = rem_q - REM_W'(1);
                    if (last_c) begin
                        drop_c  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // One-entry output register, counters and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oreg_q      <= '0;
            oval_q      <= 1'b0;
            rem_q       <= '0;
            idle_q      <= '0;
            pkt_count   <= '0;
            err_drop    <= 1'b0;
            err_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            if (load_c) oreg_q <= load_byte_c;
            oval_q      <= load_c | (oval_q & bus.fifo_full);
            rem_q       <= rem_n;
            idle_q      <= idle_n;
            if (pkt_inc_c) pkt_count <= pkt_count + 8'd1;
            err_drop    <= drop_c;
            err_timeout <= tmo_c;
            busy        <= (state_n != S_IDLE) | load_c | (oval_q & bus.fifo_full);
        end
    end

`ifdef FRAMER_CSUM_EN
    // Running XOR of header and emitted payload/pad bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum_q <= '0;
        else        csum_q <= csum_n;
    end
`endif

endmodule

// File: doc/noc_ingress_framer.md
Name: noc_ingress_framer

Overview:
- Packet framer between the chip's dedicated byte input and the first NoC FIFO of the mini-AIE 2x2 array.
- Replaces the unconditional every-cycle FIFO write with validated, length-framed packets, and respects FIFO full.
- Drops malformed packets.
- Zero-pads packets that stall mid-stream, so downstream switches never lose frame alignment.

Parameters:
- NUM_TILES, 4, number of ranks; header dest must be < NUM_TILES.
- TIMEOUT, 255, idle cycles mid-payload before abort-and-pad (1..255).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  8  incoming byte (driven from ui_in)
- in_valid  input  1  in_data valid this cycle
- in_ready  output  1  byte accepted when in_valid & in_ready
- fifo_full  input  1  full flag of downstream FIFO 0
- fifo_wr_en  output  1  write strobe to FIFO 0
- fifo_data  output  8  byte written to FIFO 0
- busy  output  1  state != IDLE or output register occupied
- err_drop  output  1  one-cycle pulse when a malformed packet finishes dropping
- err_timeout  output  1  one-cycle pulse when a timeout abort starts
- pkt_count  output  8  forwarded-packet counter, wraps 255->0

Behaviour:
- Reset: one clock, clk; reset asynchronous active-low, rst_n. Asserting rst_n low at any time, including mid-packet, clears all outputs to 0, FSM to IDLE, output register empty, counters 0.
- Header byte format:
  - [7:6] dest rank.
  - [5:4] opcode; 2'b11 reserved.
  - [3:0] payload length minus 1, giving 1..16 payload bytes.
- Output register: one entry (oreg, oval).
  - fifo_wr_en = oval & !fifo_full; fifo_data = oreg.
  - Load and drain in the same cycle are allowed, for full throughput.
  - Latency is 1 cycle from accept to fifo_wr_en when not full.
- in_ready:
  - DROP: 1.
  - IDLE/PAYLOAD: (!oval | !fifo_full).
  - PAD/CSUM: 0.
- FSM transitions:
  - IDLE, header accepted, dest < NUM_TILES and opcode != 2'b11: load header into oreg; rem = len; idle_cnt = 0; go PAYLOAD.
  - IDLE, header accepted but invalid: rem = len; go DROP. Nothing written.
  - PAYLOAD, byte accepted: load into oreg; rem--; idle_cnt = 0.
    - On last byte: pkt_count++ and go IDLE, or go CSUM if the option is enabled.
  - PAYLOAD, no accept: idle_cnt++ only while in_valid is low.
    - At idle_cnt == TIMEOUT: pulse err_timeout and go PAD. A FIFO-full stall does not count toward the timeout.
  - PAD: load 8'h00 each cycle the output register can load; rem--.
    - At rem == 0: pkt_count++ and go IDLE (or CSUM).
  - DROP: consume rem bytes.
    - On last byte: pulse err_drop and go IDLE.
- in_valid low in IDLE: no action, no timeout.
- pkt_count increments when the last byte is loaded into oreg, not when it is written to the FIFO.

Optional Feature:
- Macro: FRAMER_CSUM_EN.
- Defined:
  - After the last payload or pad byte, FSM enters CSUM.
  - CSUM emits one extra byte: the XOR of the header and all emitted payload/pad bytes.
  - The byte is loaded when the output register frees; then go IDLE.
  - in_ready = 0 in CSUM.
  - The CSUM byte is not counted in len.
- Undefined: no CSUM state, no extra byte; the running XOR register is not synthesised.

Test Plan:
- Header 8'h42 (dest 1, op 0, len 3) then bytes AA,BB,CC, FIFO never full -> fifo_wr_en pulses 4 consecutive cycles, data 42,AA,BB,CC, each 1 cycle after accept; pkt_count=1.
- Header 8'h31 (opcode 3) then 2 bytes -> no fifo_wr_en; in_ready stays 1; err_drop pulses once after the 2nd byte; pkt_count unchanged.
- Header 8'h03 (len 4), send 1 byte, then in_valid=0 for 255 cycles -> err_timeout pulse; FIFO receives 03,XX,00,00,00; pkt_count=1.
- fifo_full high for 5 cycles during payload of a 16-byte packet -> in_ready low once oreg is full; no byte lost or duplicated; no timeout; all 17 bytes arrive in order.
- rst_n low for 1 cycle mid-PAYLOAD -> outputs 0 immediately (async); next header 8'h00 + 1 byte is forwarded cleanly.
- FRAMER_CSUM_EN defined, header 8'h41 + bytes 0F,F0 -> FIFO receives 41,0F,F0,BE.
